// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a bidirectional shift register: optional load, n shifts, done pulse.
// Optional rotate fill is enabled by defining SHIFT_SEQUENCER_ROTATE_EN.
module shift_sequencer #(
   parameter int             MSB     = 4,
   parameter int             CNT_W   = 3,
   parameter logic [MSB-1:0] RST_VAL = MSB'('b1011)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic             cmd_load,
   input  logic [MSB-1:0]   cmd_data,
   input  logic             cmd_rot,
   input  logic             sin,
   input  logic             abort,
   output logic             sout,
   output logic [MSB-1:0]   out,
   output logic [CNT_W-1:0] rem,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [MSB-1:0]   out_q, out_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             leave_bit;
   logic             fill;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
   logic rot_q, rot_d;
`else
   logic unused_rot;
   assign unused_rot = cmd_rot;
`endif

   // Bit that falls off the register on the next shift, given the latched direction.
   assign leave_bit = dir_q ? out_q[MSB-1] : out_q[0];

   always_comb begin
      fill = sin;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      if (rot_q) fill = leave_bit;
`endif
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               dir_d = cmd_dir;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
               rot_d = cmd_rot;
`endif
               rem_d = cmd_cnt;
               if (cmd_load) out_d = cmd_data;
               state_d = (cmd_cnt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            // An abort freezes out and rem so the requester sees how far the command got.
            if (abort) begin
               state_d = S_DONE;
            end else begin
               out_d = dir_q ? {out_q[MSB-2:0], fill} : {fill, out_q[MSB-1:1]};
               rem_d = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         out_q   <= RST_VAL;
         rem_q   <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign sout      = (state_q == S_SHIFT) ? leave_bit : 1'b0;
   assign out       = out_q;
   assign rem       = rem_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized commands vs a reference model.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_dir, cmd_load, cmd_rot;
   logic [2:0] cmd_cnt;
   logic [3:0] cmd_data;
   logic       sin, abort, sout, busy, done;
   logic [3:0] out;
   logic [2:0] rem;

   int errors = 0;
   int checks = 0;
   int mv;    // model register value
   int mrem;  // model outstanding shifts

   shift_sequencer #(.MSB(4), .CNT_W(3), .RST_VAL(4'b1011)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt), .cmd_load(cmd_load), .cmd_data(cmd_data),
      .cmd_rot(cmd_rot), .sin(sin), .abort(abort), .sout(sout), .out(out),
      .rem(rem), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, cmd_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_sout"}, sout, 0);
      check({tag, "_out"}, out, mv);
      check({tag, "_rem"}, rem, mrem);
   endtask

   // Entered and left on a falling edge with the DUT idle.
   task automatic do_cmd(input logic dir, input int cnt, input logic ld, input logic [3:0] data,
                         input logic rot, input int abort_k, input logic [7:0] sin_pat,
                         input logic hold_valid);
      int  k;
      bit  ab;
      int  leave, fill;
      check("accept_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_cnt   = cnt[2:0];
      cmd_load  = ld;
      cmd_data  = data;
      cmd_rot   = rot;
      abort     = 1'($urandom_range(0, 1));
      @(negedge clk);
      abort     = 1'b0;
      cmd_valid = hold_valid;
      if (hold_valid) begin
         cmd_dir  = 1'($urandom);
         cmd_cnt  = 3'($urandom);
         cmd_load = 1'b1;
         cmd_data = 4'($urandom);
         cmd_rot  = 1'($urandom);
      end
      if (ld) mv = data;
      mrem = cnt;
      ab = 0;
      k = 1;
      while (k <= cnt && !ab) begin
         leave = dir ? ((mv >> 3) & 1) : (mv & 1);
         check("shift_out", out, mv);
         check("shift_rem", rem, mrem);
         check("shift_sout", sout, leave);
         check("shift_busy", busy, 1);
         check("shift_done", done, 0);
         check("shift_ready", cmd_ready, 0);
         sin   = sin_pat[k-1];
         abort = (k == abort_k);
         @(negedge clk);
         abort = 1'b0;
         if (k == abort_k) begin
            ab = 1;
         end else begin
            fill = sin_pat[k-1];
`ifdef SHIFT_SEQUENCER_ROTATE_EN
            if (rot) fill = leave;
`endif
            if (dir) mv = ((mv * 2) % 16) + fill;
            else     mv = (mv / 2) + fill * 8;
            mrem = mrem - 1;
         end
         k++;
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_ready", cmd_ready, 0);
      check("done_out", out, mv);
      check("done_rem", rem, mrem);
      check("done_sout", sout, 0);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_idle("post");
   endtask

   initial begin
      int cnt, ak;
      rst = 1'b1;
      cmd_valid = 0; cmd_dir = 0; cmd_cnt = 0; cmd_load = 0; cmd_data = 0;
      cmd_rot = 0; sin = 0; abort = 0;
      mv = 4'b1011; mrem = 0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // Right shift with load: 1001 -> 1100 -> 1110
      do_cmd(1'b0, 2, 1'b1, 4'b1001, 1'b0, 0, 8'hFF, 1'b0);
      check("right_final", out, 4'b1110);

      // Left shift from a reset value, cmd_valid held while busy
      rst = 1'b1; #1; rst = 1'b0;
      mv = 4'b1011; mrem = 0;
      @(negedge clk);
      check_idle("areset");
      do_cmd(1'b1, 3, 1'b0, 4'b0000, 1'b0, 0, 8'h00, 1'b1);
      check("left_final", out, 4'b1000);

      // Zero count
      do_cmd(1'b0, 0, 1'b1, 4'b0101, 1'b0, 0, 8'h00, 1'b0);
      check("zero_out", out, 4'b0101);

      // Abort at E2 of a 3-shift right command
      do_cmd(1'b0, 3, 1'b1, 4'b0110, 1'b0, 2, 8'h01, 1'b0);
      check("abort_rem", rem, 2);
      check("abort_out", out, 4'b1011);

      // Reset mid-SHIFT
      cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_cnt = 3'd5; cmd_load = 1'b1; cmd_data = 4'b0110;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      mv = 4'b1011; mrem = 0;
      check_idle("midreset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midreset_nodone", done, 0);
      end

      // Rotate request
      do_cmd(1'b0, 1, 1'b1, 4'b0011, 1'b1, 0, 8'h00, 1'b0);
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      check("rotate_out", out, 4'b1001);
`else
      check("rotate_out", out, 4'b0001);
`endif

      // Randomized commands
      for (int n = 0; n < 60; n++) begin
         cnt = $urandom_range(0, 7);
         ak  = ($urandom_range(0, 3) == 0 && cnt > 0) ? $urandom_range(1, cnt) : 0;
         do_cmd(1'($urandom), cnt, 1'($urandom), 4'($urandom), 1'($urandom), ak,
                8'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
